// File: rtl/rx_frame_assembler.sv
// Assembles 19-byte quote frames (sync, addr, 16 payload bytes, XOR checksum) from a UART byte stream.
// Good frames produce a one-cycle rx_dv record; bad or stalled frames are dropped, flagged and counted.
module rx_frame_assembler #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         NUM_STOCKS     = 1,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic [7:0]  rx_byte_i,
    input  logic        rx_byte_valid_i,
    output logic [7:0]  addr_o,
    output logic [31:0] rx_buyprice_o,
    output logic [31:0] rx_sellprice_o,
    output logic [31:0] rx_buyvol_o,
    output logic [31:0] rx_sellvol_o,
    output logic        rx_dv_o,
    output logic        frame_err_o,
    output logic [1:0]  err_cause_o,
    output logic [15:0] frame_count_o,
    output logic [15:0] err_count_o
);

    localparam int              TW           = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0]   TMO_LAST     = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [8:0]      NUM_STOCKS_W = 9'(NUM_STOCKS);
    localparam logic [1:0]      CAUSE_CHK    = 2'd1;
    localparam logic [1:0]      CAUSE_TMO    = 2'd2;
    localparam logic [1:0]      CAUSE_ADDR   = 2'd3;

    typedef enum logic [1:0] {HUNT, ADDR, PAYLOAD, CHK} state_t;

    state_t         state_q;
    logic [7:0]     addr_hold_q;
    logic [127:0]   payload_q;
    logic [7:0]     xor_q;
    logic [3:0]     idx_q;
    logic [TW-1:0]  tmo_q;
    logic [7:0]     addr_q;
    logic [31:0]    buyprice_q;
    logic [31:0]    sellprice_q;
    logic [31:0]    buyvol_q;
    logic [31:0]    sellvol_q;
    logic           rx_dv_q;
    logic           frame_err_q;
    logic [1:0]     err_cause_q;
    logic [15:0]    frame_count_q;
    logic [15:0]    err_count_q;

    logic [7:0]     xor_d;
    logic [15:0]    frame_count_d;
    logic [15:0]    err_count_d;
    logic           addr_in_range;

    assign xor_d         = xor_q ^ rx_byte_i;
    assign frame_count_d = (frame_count_q == 16'hFFFF) ? frame_count_q : frame_count_q + 16'd1;
    assign err_count_d   = (err_count_q == 16'hFFFF) ? err_count_q : err_count_q + 16'd1;
    assign addr_in_range = ({1'b0, addr_hold_q} < NUM_STOCKS_W);

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q       <= HUNT;
            addr_hold_q   <= '0;
            payload_q     <= '0;
            xor_q         <= '0;
            idx_q         <= '0;
            tmo_q         <= '0;
            addr_q        <= '0;
            buyprice_q    <= '0;
            sellprice_q   <= '0;
            buyvol_q      <= '0;
            sellvol_q     <= '0;
            rx_dv_q       <= 1'b0;
            frame_err_q   <= 1'b0;
            err_cause_q   <= '0;
            frame_count_q <= '0;
            err_count_q   <= '0;
        end else begin
            rx_dv_q     <= 1'b0;
            frame_err_q <= 1'b0;
            if (state_q == HUNT) begin
                tmo_q <= '0;
                if (rx_byte_valid_i && rx_byte_i == SYNC_BYTE) begin
                    state_q <= ADDR;
                    xor_q   <= '0;
                end
            end else if (rx_byte_valid_i) begin
                // An arriving byte always beats a timeout that would fire this same cycle.
                tmo_q <= '0;
                case (state_q)
                    ADDR: begin
                        addr_hold_q <= rx_byte_i;
                        xor_q       <= rx_byte_i;
                        idx_q       <= '0;
                        state_q     <= PAYLOAD;
                    end
                    PAYLOAD: begin
                        payload_q <= {payload_q[119:0], rx_byte_i};
                        xor_q     <= xor_d;
                        idx_q     <= idx_q + 4'd1;
                        if (idx_q == 4'd15) begin
                            state_q <= CHK;
                        end
                    end
                    CHK: begin
                        state_q <= HUNT;
                        if (rx_byte_i != xor_q) begin
                            frame_err_q <= 1'b1;
                            err_cause_q <= CAUSE_CHK;
                            err_count_q <= err_count_d;
                        end else if (!addr_in_range) begin
                            frame_err_q <= 1'b1;
                            err_cause_q <= CAUSE_ADDR;
                            err_count_q <= err_count_d;
                        end else begin
                            addr_q        <= addr_hold_q;
                            buyprice_q    <= payload_q[127:96];
                            sellprice_q   <= payload_q[95:64];
                            buyvol_q      <= payload_q[63:32];
                            sellvol_q     <= payload_q[31:0];
                            rx_dv_q       <= 1'b1;
                            frame_count_q <= frame_count_d;
                        end
                    end
                    default: state_q <= HUNT;
                endcase
            end else if (tmo_q == TMO_LAST) begin
                tmo_q       <= '0;
                state_q     <= HUNT;
                frame_err_q <= 1'b1;
                err_cause_q <= CAUSE_TMO;
                err_count_q <= err_count_d;
            end else begin
                tmo_q <= tmo_q + TW'(1);
            end
        end
    end

    assign addr_o         = addr_q;
    assign rx_buyprice_o  = buyprice_q;
    assign rx_sellprice_o = sellprice_q;
    assign rx_buyvol_o    = buyvol_q;
    assign rx_sellvol_o   = sellvol_q;
    assign rx_dv_o        = rx_dv_q;
    assign frame_err_o    = frame_err_q;
    assign err_cause_o    = err_cause_q;
    assign frame_count_o  = frame_count_q;
    assign err_count_o    = err_count_q;

endmodule

// File: tb/tb_rx_frame_assembler.sv
// Self-checking bench for rx_frame_assembler: directed vector table, reset-mid-frame sequence,
// and randomized frames checked against a frame-level reference model.
module tb_rx_frame_assembler;

    localparam int NUM = 1;
    localparam int TMO = 100;

    typedef logic [7:0] frame_t [19];

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] bp, sp, bv, sv;
        logic [7:0]  chk;
        int          stall_at, stall_len;
        bit          noise;
        bit          exp_dv, exp_err;
        logic [1:0]  exp_cause;
        int          exp_fc, exp_ec;
        logic [31:0] exp_bp, exp_sp, exp_bv, exp_sv;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  rx_byte;
    logic        rx_byte_valid;
    logic [7:0]  addr;
    logic [31:0] rx_buyprice, rx_sellprice, rx_buyvol, rx_sellvol;
    logic        rx_dv, frame_err;
    logic [1:0]  err_cause;
    logic [15:0] frame_count, err_count;

    always #5 clk = ~clk;

    rx_frame_assembler #(.SYNC_BYTE(8'hA5), .NUM_STOCKS(NUM), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .rx_byte_i(rx_byte), .rx_byte_valid_i(rx_byte_valid),
        .addr_o(addr), .rx_buyprice_o(rx_buyprice), .rx_sellprice_o(rx_sellprice),
        .rx_buyvol_o(rx_buyvol), .rx_sellvol_o(rx_sellvol), .rx_dv_o(rx_dv),
        .frame_err_o(frame_err), .err_cause_o(err_cause),
        .frame_count_o(frame_count), .err_count_o(err_count)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int dv_seen  = 0;
    int err_seen = 0;
    int overlap  = 0;

    // Reference model state
    int          m_fc, m_ec;
    logic [1:0]  m_cause;
    logic [7:0]  m_addr;
    logic [31:0] m_bp, m_sp, m_bv, m_sv;

    always @(negedge clk) begin
        if (rx_dv) dv_seen++;
        if (frame_err) err_seen++;
        if (rx_dv && frame_err) overlap++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Idle bus carries the sync value so ignoring it while invalid is exercised.
    task automatic send_byte(input logic [7:0] b);
        rx_byte       = b;
        rx_byte_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_byte_valid = 1'b0;
        rx_byte       = 8'hA5;
    endtask

    task automatic send_frame(input frame_t f, input int stall_at, input int stall_len, input int gap_max);
        bit stop;
        stop = 1'b0;
        for (int i = 0; i < 19; i++) begin
            if (!stop) begin
                send_byte(f[i]);
                if (i + 1 == stall_at) begin
                    idle(stall_len);
                    if (stall_len >= TMO) stop = 1'b1;
                end else if (gap_max > 0 && i < 18) begin
                    idle($urandom_range(gap_max, 0));
                end
            end
        end
    endtask

    function automatic frame_t mkf(input logic [7:0] a, input logic [31:0] bp, input logic [31:0] sp,
                                   input logic [31:0] bv, input logic [31:0] sv, input logic [7:0] c);
        frame_t f;
        f[0] = 8'hA5;
        f[1] = a;
        for (int k = 0; k < 4; k++) begin
            f[2 + k]  = bp[31 - 8*k -: 8];
            f[6 + k]  = sp[31 - 8*k -: 8];
            f[10 + k] = bv[31 - 8*k -: 8];
            f[14 + k] = sv[31 - 8*k -: 8];
        end
        f[18] = c;
        return f;
    endfunction

    task automatic check_outcome(input string tag, input bit exp_dv, input bit exp_err,
                                 input int dv0, input int err0);
        check($sformatf("%s rx_dv latency", tag), 32'(rx_dv), 32'(exp_dv));
        check($sformatf("%s frame_err latency", tag), 32'(frame_err), 32'(exp_err));
        idle(2);
        check($sformatf("%s dv pulses", tag), dv_seen - dv0, 32'(exp_dv));
        check($sformatf("%s err pulses", tag), err_seen - err0, 32'(exp_err));
        check($sformatf("%s err_cause", tag), 32'(err_cause), 32'(m_cause));
        check($sformatf("%s frame_count", tag), 32'(frame_count), m_fc);
        check($sformatf("%s err_count", tag), 32'(err_count), m_ec);
        check($sformatf("%s addr", tag), 32'(addr), 32'(m_addr));
        check($sformatf("%s buyprice", tag), rx_buyprice, m_bp);
        check($sformatf("%s sellprice", tag), rx_sellprice, m_sp);
        check($sformatf("%s buyvol", tag), rx_buyvol, m_bv);
        check($sformatf("%s sellvol", tag), rx_sellvol, m_sv);
    endtask

    vec_t   vecs [8];
    frame_t f0;

    initial begin
        vecs[0] = '{8'h00, 32'd100, 32'd101, 32'd1000, 32'd500, 8'h1F, 0, 0, 1'b0,
                    1'b1, 1'b0, 2'd0, 1, 0, 32'd100, 32'd101, 32'd1000, 32'd500};
        vecs[1] = '{8'h00, 32'd100, 32'd101, 32'd1000, 32'd500, 8'h1E, 0, 0, 1'b0,
                    1'b0, 1'b1, 2'd1, 1, 1, 32'd100, 32'd101, 32'd1000, 32'd500};
        vecs[2] = '{8'h05, 32'd100, 32'd101, 32'd1000, 32'd500, 8'h1A, 0, 0, 1'b0,
                    1'b0, 1'b1, 2'd3, 1, 2, 32'd100, 32'd101, 32'd1000, 32'd500};
        vecs[3] = '{8'h00, 32'd100, 32'd101, 32'd1000, 32'd500, 8'h1F, 8, 100, 1'b0,
                    1'b0, 1'b1, 2'd2, 1, 3, 32'd100, 32'd101, 32'd1000, 32'd500};
        vecs[4] = '{8'h00, 32'd100, 32'd101, 32'd1000, 32'd500, 8'h1F, 0, 0, 1'b0,
                    1'b1, 1'b0, 2'd2, 2, 3, 32'd100, 32'd101, 32'd1000, 32'd500};
        vecs[5] = '{8'h00, 32'h000000A5, 32'd101, 32'd1000, 32'd500, 8'hDE, 0, 0, 1'b1,
                    1'b1, 1'b0, 2'd2, 3, 3, 32'd165, 32'd101, 32'd1000, 32'd500};
        vecs[6] = '{8'h00, 32'd100, 32'd101, 32'd1000, 32'd500, 8'h1F, 8, 99, 1'b0,
                    1'b1, 1'b0, 2'd2, 4, 3, 32'd100, 32'd101, 32'd1000, 32'd500};
        vecs[7] = '{8'hA5, 32'd100, 32'd101, 32'd1000, 32'd500, 8'hBA, 0, 0, 1'b0,
                    1'b0, 1'b1, 2'd3, 4, 4, 32'd100, 32'd101, 32'd1000, 32'd500};
        f0 = mkf(8'h00, 32'd100, 32'd101, 32'd1000, 32'd500, 8'h1F);

        reset_n       = 1'b0;
        rx_byte       = 8'h00;
        rx_byte_valid = 1'b0;
        idle(3);
        reset_n = 1'b1;
        check("reset addr", 32'(addr), 32'd0);
        check("reset buyprice", rx_buyprice, 32'd0);
        check("reset sellvol", rx_sellvol, 32'd0);
        check("reset rx_dv", 32'(rx_dv), 32'd0);
        check("reset frame_err", 32'(frame_err), 32'd0);
        check("reset err_cause", 32'(err_cause), 32'd0);
        check("reset frame_count", 32'(frame_count), 32'd0);
        check("reset err_count", 32'(err_count), 32'd0);

        // Directed vector table
        m_addr = 8'h00;
        for (int v = 0; v < 8; v++) begin
            int dv0, err0;
            dv0  = dv_seen;
            err0 = err_seen;
            if (vecs[v].noise) begin
                send_byte(8'h11);
                send_byte(8'h22);
                send_byte(8'h33);
            end
            send_frame(mkf(vecs[v].addr, vecs[v].bp, vecs[v].sp, vecs[v].bv, vecs[v].sv, vecs[v].chk),
                       vecs[v].stall_at, vecs[v].stall_len, 0);
            m_cause = vecs[v].exp_cause;
            m_fc    = vecs[v].exp_fc;
            m_ec    = vecs[v].exp_ec;
            m_bp    = vecs[v].exp_bp;
            m_sp    = vecs[v].exp_sp;
            m_bv    = vecs[v].exp_bv;
            m_sv    = vecs[v].exp_sv;
            check_outcome($sformatf("vec%0d", v), vecs[v].exp_dv, vecs[v].exp_err, dv0, err0);
            $display("vec%0d: dv=%0b err=%0b cause=%0d fc=%0d ec=%0d", v, vecs[v].exp_dv,
                     vecs[v].exp_err, err_cause, frame_count, err_count);
        end

        // Reset after the 10th byte of a frame, then a complete good frame
        begin
            int dv0, err0;
            err0 = err_seen;
            for (int i = 0; i < 10; i++) send_byte(f0[i]);
            reset_n = 1'b0;
            idle(1);
            reset_n = 1'b1;
            idle(2);
            check("midreset frame_count", 32'(frame_count), 32'd0);
            check("midreset err_count", 32'(err_count), 32'd0);
            check("midreset err_cause", 32'(err_cause), 32'd0);
            check("midreset buyprice", rx_buyprice, 32'd0);
            check("midreset no frame_err", err_seen - err0, 32'd0);
            dv0  = dv_seen;
            err0 = err_seen;
            send_frame(f0, 0, 0, 0);
            m_fc = 1; m_ec = 0; m_cause = 2'd0; m_addr = 8'h00;
            m_bp = 32'd100; m_sp = 32'd101; m_bv = 32'd1000; m_sv = 32'd500;
            check_outcome("midreset frame", 1'b1, 1'b0, dv0, err0);
            $display("reset mid-frame: fc=%0d ec=%0d", frame_count, err_count);
        end

        // Randomized frames against the frame-level model
        for (int r = 0; r < 40; r++) begin
            frame_t     f;
            int         kind, stall_at, stall_len, dv0, err0;
            logic [7:0] x, nb;
            bit         good, bad;
            dv0  = dv_seen;
            err0 = err_seen;
            kind = $urandom_range(7, 0);
            f = mkf((kind == 6) ? 8'($urandom_range(255, 1)) : 8'($urandom_range(NUM - 1, 0)),
                    $urandom, $urandom, $urandom, $urandom, 8'h00);
            x = 8'h00;
            for (int i = 1; i < 18; i++) x ^= f[i];
            f[18] = (kind == 5) ? (x ^ 8'($urandom_range(255, 1))) : x;
            stall_at  = 0;
            stall_len = 0;
            if (kind == 7) begin
                stall_at  = $urandom_range(18, 1);
                stall_len = TMO;
            end else if ($urandom_range(9, 0) == 0) begin
                stall_at  = $urandom_range(18, 1);
                stall_len = TMO - 1;
            end
            for (int n = $urandom_range(2, 0); n > 0; n--) begin
                nb = 8'($urandom_range(255, 0));
                if (nb == 8'hA5) nb = 8'h5A;
                send_byte(nb);
            end
            send_frame(f, stall_at, stall_len, 2);

            good = 1'b0;
            bad  = 1'b1;
            if (stall_len >= TMO) m_cause = 2'd2;
            else if (x != f[18]) m_cause = 2'd1;
            else if (int'(f[1]) >= NUM) m_cause = 2'd3;
            else begin
                good = 1'b1;
                bad  = 1'b0;
            end
            if (good) begin
                if (m_fc < 65535) m_fc++;
                m_addr = f[1];
                m_bp = {f[2], f[3], f[4], f[5]};
                m_sp = {f[6], f[7], f[8], f[9]};
                m_bv = {f[10], f[11], f[12], f[13]};
                m_sv = {f[14], f[15], f[16], f[17]};
            end else if (m_ec < 65535) begin
                m_ec++;
            end
            check_outcome($sformatf("rand%0d", r), good, bad, dv0, err0);
            $display("rand%0d: kind=%0d stall=%0d@%0d good=%0b fc=%0d ec=%0d", r, kind, stall_len,
                     stall_at, good, frame_count, err_count);
        end

        check("rx_dv/frame_err overlap", overlap, 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_frame_assembler.md
Name: rx_frame_assembler

Overview:
- Sits between the UART byte receiver and the per-stock rx demultiplexer.
- Hunts for a sync byte, then collects an address byte, 16 big-endian payload bytes and an XOR checksum from the byte stream.
- On a valid frame, drives one quote record (addr, buy/sell price, buy/sell volume) with a single-cycle rx_dv strobe.
- Bad frames (checksum mismatch, out-of-range address, inter-byte timeout) are dropped, flagged and counted.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- NUM_STOCKS, 1, valid addresses are 0..NUM_STOCKS-1.
- TIMEOUT_CYCLES, 50000, maximum clk cycles allowed between consecutive bytes inside a frame.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- rx_byte  in  8  received byte from the UART byte receiver.
- rx_byte_valid  in  1  one-cycle strobe; rx_byte is valid while it is high.
- addr  out  8  stock address of the last good frame.
- rx_buyprice  out  32  buy price of the last good frame.
- rx_sellprice  out  32  sell price of the last good frame.
- rx_buyvol  out  32  buy volume of the last good frame.
- rx_sellvol  out  32  sell volume of the last good frame.
- rx_dv  out  1  one-cycle strobe marking a new good record.
- frame_err  out  1  one-cycle strobe marking a dropped frame.
- err_cause  out  2  reason for the last drop: 1 = checksum, 2 = timeout, 3 = bad address; held until the next error.
- frame_count  out  16  good frames received; saturates at 16'hFFFF.
- err_count  out  16  dropped frames; saturates at 16'hFFFF.

Behaviour:
- Clock and reset:
  - Single clock domain. Reset is synchronous and active-low; it is sampled only on posedge clk.
  - Reset clears all outputs, counters, the shift register and the timeout counter, and puts the FSM in HUNT.
  - Reset mid-frame discards the partial frame with no frame_err and no count change.
- Frame format, 19 bytes in order:
  - SYNC_BYTE
  - addr
  - buyprice[31:24..7:0]
  - sellprice[31:24..7:0]
  - buyvol[31:24..7:0]
  - sellvol[31:24..7:0]
  - chk, where chk = XOR of addr and all 16 payload bytes (SYNC_BYTE is excluded).
- FSM:
  - HUNT: ignore every byte except SYNC_BYTE. On SYNC_BYTE go to ADDR, clear the running XOR and reset the timeout counter.
  - ADDR: on a byte, latch addr into a holding register, XOR = byte, go to PAYLOAD with byte index 0.
  - PAYLOAD: on each byte, shift it into a 128-bit holding register MSB-first and XOR it into the checksum. Index counts 0..15; after index 15 go to CHK.
  - CHK: on a byte, compare it with the running XOR and go to HUNT.
    - Match and held addr < NUM_STOCKS: good frame.
    - Mismatch: error, cause 1. Checksum is checked first, so it takes priority over a bad address.
    - Match but held addr >= NUM_STOCKS: error, cause 3.
- Any byte value, including SYNC_BYTE, is treated as data outside HUNT. There is no resync mid-frame.
- Good frame:
  - On the clk edge after the cycle in which the CHK byte is sampled, the addr and price/volume outputs update, rx_dv = 1 for exactly one cycle, and frame_count increments.
  - Latency from the checksum byte's rx_byte_valid to rx_dv is 1 cycle.
  - Data outputs hold their values until the next good frame.
- Error:
  - frame_err = 1 for one cycle with the same latency as rx_dv, err_cause is updated and err_count increments.
  - Data outputs and rx_dv are unchanged.
- Timeout:
  - In ADDR, PAYLOAD or CHK, a counter increments every cycle without rx_byte_valid and clears on rx_byte_valid.
  - When it reaches TIMEOUT_CYCLES: frame_err pulses, err_cause = 2, err_count increments, FSM goes to HUNT.
  - If rx_byte_valid arrives in the same cycle the count would reach the limit, the byte wins: it is accepted and the counter clears.
  - The counter does not run in HUNT.
- rx_dv and frame_err are never high in the same cycle.
- Good records are at least 19 byte-times apart. This guarantees the downstream 3-cycle dead time between strobes.
- Counters saturate at 16'hFFFF and do not wrap.

Test Plan:
- Good frame: after reset, send A5 00 00 00 00 64 00 00 00 65 00 00 03 E8 00 00 01 F4 1F.
  - Required: one rx_dv pulse 1 cycle after the last byte, with addr=0, buyprice=100, sellprice=101, buyvol=1000, sellvol=500, frame_count=1.
- Bad checksum: same frame with last byte 1E.
  - Required: frame_err pulse, err_cause=1, err_count=1, no rx_dv, outputs still hold the prior values.
- Bad address: addr=05 with NUM_STOCKS=1 and checksum recomputed to 1A.
  - Required: frame_err pulse, err_cause=3, no rx_dv.
- Timeout and recovery: set TIMEOUT_CYCLES=100, then stall 100 cycles after the 8th byte.
  - Required: frame_err pulse with err_cause=2, then a following good frame produces rx_dv.
- Leading noise and embedded sync: send 3 noise bytes (11 22 33), then a good frame whose payload contains A5.
  - Required: the noise is ignored, exactly one rx_dv, payload decoded correctly.
- Reset mid-frame: assert reset_n low for 1 cycle after the 10th byte, then send a full good frame.
  - Required: no frame_err, counters at 0 after reset, and the full frame yields rx_dv with frame_count=1.
